// File: rtl/gpioemu_host.sv
// -----------------------------------------------------------------------------
// gpioemu_host
// Bus initiator for the gpioemu multiplier/popcount peripheral. A request writes
// both 24-bit operands and the trigger, polls the status register until the
// peripheral reports ready (or a poll budget runs out), reads back the product
// low word and its ones count, and reports completion with a one-cycle pulse.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   start             one-cycle request, only looked at while idle
//   arg_a, arg_b      operands, captured when start is accepted
//   busy              request in progress (low again in the done cycle)
//   done              one-cycle completion pulse
//   err_timeout       qualifies done: status never reported ready
//   res_w, res_l      product bits [31:0] and its ones count
//   res_valid         status B[0] of the final poll (product fits in 32 bits)
//   saddress, srd,
//   swr, sdata_out,
//   sdata_in          peripheral bus
// -----------------------------------------------------------------------------
module gpioemu_host #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned POLL_LIMIT = 64,
    parameter logic [15:0] ADDR_A1    = 16'h037F,
    parameter logic [15:0] ADDR_A2    = 16'h0388,
    parameter logic [15:0] ADDR_CTRL  = 16'h03A0,
    parameter logic [15:0] ADDR_W     = 16'h0390,
    parameter logic [15:0] ADDR_L     = 16'h0398
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] arg_a,
    input  logic [23:0] arg_b,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic [31:0] res_w,
    output logic [23:0] res_l,
    output logic        res_valid,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    localparam logic [15:0] C_SETUP_LAST  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] C_STROBE_LAST = 16'(STROBE_CYC - 1);
    localparam logic [15:0] C_SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] C_POLL_LAST   = 16'(POLL_LIMIT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_SETTLE,
        S_POLL, S_RD_W0, S_RD_W1, S_RD_L, S_FIN
    } seq_t;

    typedef enum logic [1:0] {
        PH_IDLE, PH_SETUP, PH_STROBE, PH_RECOVER
    } ph_t;

    seq_t        r_seq, w_seq_nxt;
    ph_t         r_ph, w_ph_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;     // phase timer, reused as settle timer
    logic [15:0] r_polls;              // polls that came back not-ready
    logic [23:0] r_a, r_b;
    logic [1:0]  r_stat;               // status B[1:0] of the current poll
    logic        r_err;

    logic        w_is_read;
    logic        w_last_strobe;
    logic        w_xfer_done;

    assign w_last_strobe = (r_ph == PH_STROBE) && (r_cnt == C_STROBE_LAST);
    assign w_xfer_done   = (r_ph == PH_RECOVER);

    // Sequence and bus-phase next state. The phase FSM free-runs
    // SETUP->STROBE->RECOVER->SETUP; the sequence FSM overrides it when it
    // enters or leaves a bus-owning state.
    always_comb begin
        w_seq_nxt = r_seq;
        w_ph_nxt  = r_ph;
        w_cnt_nxt = r_cnt;

        case (r_ph)
            PH_SETUP: begin
                if (r_cnt == C_SETUP_LAST) begin
                    w_ph_nxt  = PH_STROBE;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            PH_STROBE: begin
                if (r_cnt == C_STROBE_LAST) begin
                    w_ph_nxt  = PH_RECOVER;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            PH_RECOVER: begin
                w_ph_nxt  = PH_SETUP;
                w_cnt_nxt = '0;
            end
            default: ;
        endcase

        case (r_seq)
            S_IDLE: begin
                if (start) begin
                    w_seq_nxt = S_WR_A1;
                    w_ph_nxt  = PH_SETUP;
                    w_cnt_nxt = '0;
                end
            end
            S_WR_A1: if (w_xfer_done) w_seq_nxt = S_WR_A2;
            S_WR_A2: if (w_xfer_done) w_seq_nxt = S_WR_GO;
            S_WR_GO: begin
                if (w_xfer_done) begin
                    w_seq_nxt = S_SETTLE;
                    w_ph_nxt  = PH_IDLE;
                    w_cnt_nxt = '0;
                end
            end
            S_SETTLE: begin
                if (r_cnt == C_SETTLE_LAST) begin
                    w_seq_nxt = S_POLL;
                    w_ph_nxt  = PH_SETUP;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_POLL: begin
                // Not ready and budget left: stay here, the phase FSM
                // already restarts the next read.
                if (w_xfer_done) begin
                    if (r_stat[1]) begin
                        w_seq_nxt = S_RD_W0;
                    end else if (r_polls == C_POLL_LAST) begin
                        w_seq_nxt = S_FIN;
                        w_ph_nxt  = PH_IDLE;
                    end
                end
            end
            S_RD_W0: if (w_xfer_done) w_seq_nxt = S_RD_W1;
            S_RD_W1: if (w_xfer_done) w_seq_nxt = S_RD_L;
            S_RD_L: begin
                if (w_xfer_done) begin
                    w_seq_nxt = S_FIN;
                    w_ph_nxt  = PH_IDLE;
                end
            end
            S_FIN: begin
                w_seq_nxt = S_IDLE;
                w_ph_nxt  = PH_IDLE;
            end
            default: begin
                w_seq_nxt = S_IDLE;
                w_ph_nxt  = PH_IDLE;
            end
        endcase
    end

    // Bus drive decoded from the sequence state; the address stays put for
    // the whole SETUP/STROBE/RECOVER span of a transaction.
    always_comb begin
        saddress  = '0;
        sdata_out = '0;
        w_is_read = 1'b0;
        case (r_seq)
            S_WR_A1: begin
                saddress  = ADDR_A1;
                sdata_out = {8'h00, r_a};
            end
            S_WR_A2: begin
                saddress  = ADDR_A2;
                sdata_out = {8'h00, r_b};
            end
            S_WR_GO: saddress = ADDR_CTRL;
            S_POLL: begin
                saddress  = ADDR_CTRL;
                w_is_read = 1'b1;
            end
            S_RD_W0, S_RD_W1: begin
                saddress  = ADDR_W;
                w_is_read = 1'b1;
            end
            S_RD_L: begin
                saddress  = ADDR_L;
                w_is_read = 1'b1;
            end
            default: ;
        endcase
    end

    assign srd         = (r_ph == PH_STROBE) &&  w_is_read;
    assign swr         = (r_ph == PH_STROBE) && !w_is_read;
    assign busy        = (r_seq != S_IDLE) && (r_seq != S_FIN);
    assign done        = (r_seq == S_FIN);
    assign err_timeout = done && r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq     <= S_IDLE;
            r_ph      <= PH_IDLE;
            r_cnt     <= '0;
            r_polls   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_stat    <= '0;
            r_err     <= 1'b0;
            res_w     <= '0;
            res_l     <= '0;
            res_valid <= 1'b0;
        end else begin
            r_seq <= w_seq_nxt;
            r_ph  <= w_ph_nxt;
            r_cnt <= w_cnt_nxt;

            if (r_seq == S_IDLE && start) begin
                r_a     <= arg_a;
                r_b     <= arg_b;
                r_polls <= '0;
                r_err   <= 1'b0;
            end

            // Read data is taken on the final strobe cycle. The RD_W0 value
            // is stale (peripheral W lags one read) and is dropped.
            if (w_last_strobe) begin
                case (r_seq)
                    S_POLL:  r_stat <= sdata_in[1:0];
                    S_RD_W1: res_w  <= sdata_in;
                    S_RD_L:  res_l  <= sdata_in[23:0];
                    default: ;
                endcase
            end

            if (r_seq == S_POLL && w_xfer_done) begin
                if (r_stat[1]) begin
                    res_valid <= r_stat[0];
                end else if (r_polls == C_POLL_LAST) begin
                    r_err <= 1'b1;
                end else begin
                    r_polls <= r_polls + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpioemu_host.sv
// -----------------------------------------------------------------------------
// tb_gpioemu_host
// Directed bench for gpioemu_host with a behavioural gpioemu peripheral, a bus
// monitor and scoreboards for bus transactions and results.
// -----------------------------------------------------------------------------
module tb_gpioemu_host;

    localparam logic [15:0] A_A1   = 16'h037F;
    localparam logic [15:0] A_A2   = 16'h0388;
    localparam logic [15:0] A_CTRL = 16'h03A0;
    localparam logic [15:0] A_W    = 16'h0390;
    localparam logic [15:0] A_L    = 16'h0398;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] arg_a = '0;
    logic [23:0] arg_b = '0;
    logic        busy, done, err_timeout, res_valid, srd, swr;
    logic [31:0] res_w, sdata_out, sdata_in;
    logic [23:0] res_l;
    logic [15:0] saddress;

    gpioemu_host dut (
        .clk(clk), .reset(reset), .start(start), .arg_a(arg_a), .arg_b(arg_b),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .res_w(res_w), .res_l(res_l), .res_valid(res_valid),
        .saddress(saddress), .srd(srd), .swr(swr),
        .sdata_out(sdata_out), .sdata_in(sdata_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [31:0] d;
    } txn_t;

    typedef struct {
        logic [31:0] w;
        logic [23:0] l;
        logic        v;
        logic        e;
        int          lat;
    } res_t;

    txn_t txn_q[$];
    res_t res_q[$];
    res_t last_res;

    task automatic push_txn(input logic wr, input logic [15:0] a, input logic [31:0] d);
        txn_t t;
        t.wr = wr; t.a = a; t.d = wr ? d : 32'h0;
        txn_q.push_back(t);
    endtask

    // ---------------- peripheral model ----------------
    logic [23:0] pm_a1 = '0;
    logic [23:0] pm_a2 = '0;
    logic [31:0] pm_wlag = 32'hDEAD_BEEF;
    logic [47:0] pm_prod;
    logic        pm_ready;
    int          pm_polls = 0;
    int          ready_at = 1;     // poll number that first reports ready; 0 = never

    always_comb begin
        pm_prod  = {24'h0, pm_a1} * {24'h0, pm_a2};
        pm_ready = (ready_at != 0) && (pm_polls + 1 >= ready_at);
        case (saddress)
            A_CTRL:  sdata_in = {30'h0, pm_ready, (pm_prod[47:32] == 16'h0)};
            A_W:     sdata_in = pm_wlag;
            A_L:     sdata_in = 32'($countones(pm_prod[31:0]));
            default: sdata_in = 32'hA5A5_A5A5;
        endcase
    end

    // ---------------- bus monitor ----------------
    int          setup_run = 0;
    int          hi_run = 0;
    logic        p_srd = 1'b0;
    logic        p_swr = 1'b0;
    logic [15:0] p_addr = '0;
    txn_t        mon_e;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            setup_run = 0;
            hi_run    = 0;
            p_srd     = 1'b0;
            p_swr     = 1'b0;
            p_addr    = saddress;
        end else begin
            if (srd || swr) begin
                chk("bus_exclusive", 64'(srd & swr), 64'd0);
                if (!p_srd && !p_swr) begin
                    chk("setup_cycles", 64'(setup_run >= 2), 64'd1);
                    if (txn_q.size() == 0) begin
                        chk("txn_unexpected", 64'({swr, saddress}), 64'h0);
                    end else begin
                        mon_e = txn_q.pop_front();
                        chk("txn", 64'({swr, saddress, swr ? sdata_out : 32'h0}),
                            64'({mon_e.wr, mon_e.a, mon_e.d}));
                    end
                    if (swr) begin
                        if (saddress == A_A1) pm_a1 = sdata_out[23:0];
                        if (saddress == A_A2) pm_a2 = sdata_out[23:0];
                        if (saddress == A_CTRL) pm_polls = 0;
                    end
                    hi_run = 0;
                end
                hi_run++;
                setup_run = 0;
            end else begin
                if (p_srd || p_swr) begin
                    chk("strobe_width", 64'(hi_run), 64'd2);
                    if (p_srd && saddress == A_W) pm_wlag = pm_prod[31:0];
                    if (p_srd && saddress == A_CTRL) pm_polls++;
                end
                setup_run = (saddress == p_addr) ? setup_run + 1 : 1;
            end
            p_srd  = srd;
            p_swr  = swr;
            p_addr = saddress;
        end
    end

    // ---------------- one request ----------------
    task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                          input int rdy, input bit hold);
        res_t        r;
        logic [47:0] p;
        int          np;
        int          n;
        bit          got;
        p  = {24'h0, a} * {24'h0, b};
        np = (rdy == 0) ? 64 : rdy;
        ready_at = rdy;
        push_txn(1'b1, A_A1, {8'h0, a});
        push_txn(1'b1, A_A2, {8'h0, b});
        push_txn(1'b1, A_CTRL, 32'h0);
        for (int i = 0; i < np; i++) push_txn(1'b0, A_CTRL, 32'h0);
        if (rdy != 0) begin
            push_txn(1'b0, A_W, 32'h0);
            push_txn(1'b0, A_W, 32'h0);
            push_txn(1'b0, A_L, 32'h0);
            r.w   = p[31:0];
            r.l   = 24'($countones(p[31:0]));
            r.v   = (p[47:32] == 16'h0);
            r.e   = 1'b0;
            r.lat = 3*5 + 8 + 5*np + 15 + 1;
            last_res = r;
        end else begin
            r     = last_res;
            r.e   = 1'b1;
            r.lat = 3*5 + 8 + 5*64 + 1;
        end
        res_q.push_back(r);

        arg_a = a;
        arg_b = b;
        start = 1'b1;
        n = 0;
        got = 0;
        while (n < 1000 && !got) begin
            @(posedge clk); #1;
            n++;
            if (!hold) start = 1'b0;
            if (n == 1) chk("busy_after_start", 64'(busy), 64'd1);
            if (done) got = 1;
        end
        start = 1'b0;
        r = res_q.pop_front();
        if (!got) begin
            chk("done_seen", 64'd0, 64'd1);
        end else begin
            chk("latency", 64'(n), 64'(r.lat));
            chk("res_w", 64'(res_w), 64'(r.w));
            chk("res_l", 64'(res_l), 64'(r.l));
            chk("res_valid", 64'(res_valid), 64'(r.v));
            chk("err_timeout", 64'(err_timeout), 64'(r.e));
            chk("busy_in_done", 64'(busy), 64'd0);
            if (rdy == 0) chk("poll_count", 64'(pm_polls), 64'd64);
        end
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("txn_drained", 64'(txn_q.size()), 64'd0);
    endtask

    int dn;
    int w;

    initial begin
        last_res.w = '0; last_res.l = '0; last_res.v = 1'b0; last_res.e = 1'b0; last_res.lat = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_res_w", 64'(res_w), 64'd0);
        chk("rst_res_l", 64'(res_l), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_bus", 64'({saddress, srd, swr}), 64'd0);
        chk("rst_wdata", 64'(sdata_out), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // basic product, ready on first poll
        run_op(24'd3, 24'd5, 1, 1'b0);
        // largest operands, ready on third poll, product overflows 32 bits
        run_op(24'hFFFFFF, 24'hFFFFFF, 3, 1'b0);
        // status never ready: timeout, results kept
        run_op(24'h000010, 24'h000020, 0, 1'b0);
        // start held high for the whole request
        run_op(24'h123456, 24'h00ABCD, 2, 1'b1);
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("no_extra_done", 64'(dn), 64'd0);
        chk("no_extra_txn", 64'(txn_q.size()), 64'd0);

        // reset during the WR_A2 strobe
        push_txn(1'b1, A_A1, {8'h0, 24'h000007});
        push_txn(1'b1, A_A2, {8'h0, 24'h000009});
        arg_a = 24'h000007;
        arg_b = 24'h000009;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (w < 100 && !(swr && saddress == A_A2)) begin
            @(posedge clk); #1;
            w++;
        end
        chk("reached_wr_a2", 64'(swr && saddress == A_A2), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_strobes", 64'({srd, swr}), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_res_w", 64'(res_w), 64'd0);
        chk("rst_mid_txn", 64'(txn_q.size()), 64'd0);
        txn_q.delete();
        reset = 1'b0;
        last_res.w = '0; last_res.l = '0; last_res.v = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("rst_mid_no_done", 64'(dn), 64'd0);
        run_op(24'h0000FF, 24'h000101, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
